// File: rtl/fir_scheduler.sv
// fir_scheduler
//   Sequencing front-end for the FIR filter controller. Serialises coefficient
//   reloads (4 coefficients, atomic) and sample arrivals onto the controller's
//   lc/dr handshake, tracks completion through modwait, and reports errors,
//   dropped samples and watchdog expiry.
//
// Ports
//   clk, n_rst        system clock (rising edge), async active-low reset
//   new_coeff_set     level, host requests a reload of all 4 coefficients
//   sample_valid      pulse, a new sample is in the host sample register
//   modwait, err      controller busy / error flags
//   load_coeff        controller lc
//   data_ready        controller dr
//   coeff_num[1:0]    index of the coefficient being loaded
//   clear_coeff_set   pulse, reload complete (host clears new_coeff_set)
//   busy              high whenever not IDLE
//   sample_overrun    pulse, a sample was dropped
//   sample_err        pulse, a sample run ended with err=1
//   fault             pulse, watchdog expired
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | nothing in flight; reloads win over samples
// C_ISSUE | lc asserted, waiting for modwait to rise (watchdog running)
// C_WAIT  | controller loading coefficient coeff_num, waiting for modwait=0
// C_DONE  | reload finished, clear_coeff_set pulse
// S_ISSUE | dr asserted, waiting for modwait to rise (watchdog running)
// S_WAIT  | controller processing the sample, waiting for modwait=0
// FAULT   | watchdog expired, one-cycle fault pulse

module fir_scheduler #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       new_coeff_set,
    input  logic       sample_valid,
    input  logic       modwait,
    input  logic       err,
    output logic       load_coeff,
    output logic       data_ready,
    output logic [1:0] coeff_num,
    output logic       clear_coeff_set,
    output logic       busy,
    output logic       sample_overrun,
    output logic       sample_err,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        C_ISSUE = 3'd1,
        C_WAIT  = 3'd2,
        C_DONE  = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [1:0] coeff_num_q, coeff_num_d;
    logic       pend_q, pend_d;
    logic [7:0] wdog_q, wdog_d;
    logic       sample_overrun_q, sample_overrun_d;
    logic       sample_err_q, sample_err_d;

    logic       in_issue;
    assign in_issue = (state_q == C_ISSUE) || (state_q == S_ISSUE);

    // state and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q          <= IDLE;
            coeff_num_q      <= 2'd0;
            pend_q           <= 1'b0;
            wdog_q           <= 8'd0;
            sample_overrun_q <= 1'b0;
            sample_err_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            coeff_num_q      <= coeff_num_d;
            pend_q           <= pend_d;
            wdog_q           <= wdog_d;
            sample_overrun_q <= sample_overrun_d;
            sample_err_q     <= sample_err_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (new_coeff_set)
                    state_d = C_ISSUE;
                else if (pend_q || sample_valid)
                    state_d = S_ISSUE;
            end
            C_ISSUE: begin
                if (modwait)
                    state_d = C_WAIT;
                else if (wdog_q == WDOG_LAST)
                    state_d = FAULT;
            end
            C_WAIT: begin
                if (!modwait)
                    state_d = (coeff_num_q == 2'd3) ? C_DONE : C_ISSUE;
            end
            C_DONE: state_d = IDLE;
            S_ISSUE: begin
                if (modwait)
                    state_d = S_WAIT;
                else if (wdog_q == WDOG_LAST)
                    state_d = FAULT;
            end
            S_WAIT: begin
                if (!modwait)
                    state_d = IDLE;
            end
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // coefficient index, pending sample flag, watchdog, event pulses
    always_comb begin
        coeff_num_d      = coeff_num_q;
        pend_d           = pend_q;
        wdog_d           = wdog_q;
        sample_overrun_d = 1'b0;
        sample_err_d     = (state_q == S_WAIT) && !modwait && err;

        if (state_q == IDLE && new_coeff_set)
            coeff_num_d = 2'd0;
        else if (state_q == C_WAIT && !modwait && coeff_num_q != 2'd3)
            coeff_num_d = coeff_num_q + 2'd1;
        else if (state_q == C_DONE || state_q == FAULT)
            coeff_num_d = 2'd0;

        if (state_q == IDLE) begin
            if (new_coeff_set) begin
                // reload wins; a concurrent sample waits behind it
                pend_d           = pend_q | sample_valid;
                sample_overrun_d = pend_q & sample_valid;
            end else if (pend_q || sample_valid) begin
                // serve the held sample first, keep a fresh one pending
                pend_d = pend_q & sample_valid;
            end
        end else if (state_q == FAULT) begin
            pend_d = 1'b0;
        end else if (sample_valid) begin
            pend_d           = 1'b1;
            sample_overrun_d = pend_q;
        end

        // restart on every entry into an issue state, including C_WAIT->C_ISSUE
        if ((state_d == C_ISSUE || state_d == S_ISSUE) && state_d != state_q)
            wdog_d = 8'd0;
        else if (in_issue)
            wdog_d = wdog_q + 8'd1;
    end

    // Moore outputs
    always_comb begin
        load_coeff      = (state_q == C_ISSUE);
        data_ready      = (state_q == S_ISSUE);
        clear_coeff_set = (state_q == C_DONE);
        fault           = (state_q == FAULT);
        busy            = (state_q != IDLE);
        coeff_num       = coeff_num_q;
        sample_overrun  = sample_overrun_q;
        sample_err      = sample_err_q;
    end

endmodule

// File: tb/tb_fir_scheduler.sv
// Testbench for fir_scheduler with a simple controller model (modwait rises
// one cycle after lc/dr and stays high HOLD cycles). Expected pulses are queued
// per output by the stimulus; a monitor measures each output pulse and pops.

module tb_fir_scheduler;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       new_coeff_set, sample_valid, modwait, err;
    logic       load_coeff, data_ready, clear_coeff_set, busy;
    logic       sample_overrun, sample_err, fault;
    logic [1:0] coeff_num;

    fir_scheduler #(.TIMEOUT(8)) dut (
        .clk(clk), .n_rst(n_rst),
        .new_coeff_set(new_coeff_set), .sample_valid(sample_valid),
        .modwait(modwait), .err(err),
        .load_coeff(load_coeff), .data_ready(data_ready), .coeff_num(coeff_num),
        .clear_coeff_set(clear_coeff_set), .busy(busy),
        .sample_overrun(sample_overrun), .sample_err(sample_err), .fault(fault)
    );

    always #5 clk = ~clk;

    // controller model
    logic mw_en;
    int   hold;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            modwait <= 1'b0;
            hold    <= 0;
        end else if (mw_en) begin
            if (!modwait) begin
                if (load_coeff || data_ready) begin
                    modwait <= 1'b1;
                    hold    <= HOLD - 1;
                end
            end else if (hold == 0) begin
                modwait <= 1'b0;
            end else begin
                hold <= hold - 1;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: 0 lc (coeff*16+width), 1 dr, 2 clear, 3 overrun, 4 serr, 5 fault (width)
    int    exp_q[6][$];
    string names[6] = '{"load_coeff", "data_ready", "clear_coeff_set",
                        "sample_overrun", "sample_err", "fault"};
    int    wid[6] = '{0, 0, 0, 0, 0, 0};
    int    rise_coeff = 0;
    int    lc_falls = 0;
    int    dr_falls = 0;

    always @(negedge clk) begin
        logic [5:0] s;
        int obs;
        s = {fault, sample_err, sample_overrun, clear_coeff_set, data_ready, load_coeff};
        for (int k = 0; k < 6; k++) begin
            if (s[k]) begin
                if (k == 0 && wid[0] == 0) rise_coeff = int'(coeff_num);
                wid[k]++;
            end else if (wid[k] != 0) begin
                obs = (k == 0) ? rise_coeff * 16 + wid[k] : wid[k];
                if (exp_q[k].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected %s pulse: got %0d, expected none", names[k], obs);
                end else begin
                    check(names[k], obs, exp_q[k].pop_front());
                end
                if (k == 0) lc_falls++;
                if (k == 1) dr_falls++;
                wid[k] = 0;
            end
        end
    end

    task automatic push_reload();
        for (int c = 0; c < 4; c++) exp_q[0].push_back(c * 16 + 2);
        exp_q[2].push_back(1);
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 300 && quiet < 3; i++) begin
            @(negedge clk); #1;
            quiet = busy ? 0 : quiet + 1;
        end
        check("return_to_idle", int'(quiet >= 3), 1);
    endtask

    // waits for clear_coeff_set, checks no data_ready happened since dr_start,
    // then releases new_coeff_set inside C_DONE
    task automatic wait_cc(input int dr_start);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk); #1;
            if (clear_coeff_set) seen = 1;
        end
        check("clear_coeff_set_seen", int'(seen), 1);
        check("no_dr_during_reload", dr_falls - dr_start + int'(data_ready), 0);
        new_coeff_set = 1'b0;
    endtask

    task automatic wait_lc_falls(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            if (lc_falls >= target) ok = 1;
        end
        check("lc_fall_reached", int'(ok), 1);
    endtask

    initial begin
        n_rst = 1'b0; new_coeff_set = 1'b0; sample_valid = 1'b0; err = 1'b0; mw_en = 1'b1;
        #1;
        check("reset_outputs",
              int'({load_coeff, data_ready, clear_coeff_set, busy,
                    sample_overrun, sample_err, fault, coeff_num}), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset_busy", int'(busy), 0);

        // single sample
        exp_q[1].push_back(2);
        @(negedge clk); #1 sample_valid = 1'b1;
        @(negedge clk); sample_valid = 1'b0;
        check("sample_latency_dr", int'(data_ready), 1);
        @(negedge clk); check("sample_dr_2nd", int'(data_ready), 1);
        @(negedge clk); check("sample_dr_drop", int'(data_ready), 0);
        check("sample_busy_hold", int'(busy), 1);
        wait_idle();

        // reload
        push_reload();
        new_coeff_set = 1'b1;
        @(negedge clk);
        check("reload_latency_lc", int'(load_coeff), 1);
        check("reload_first_coeff", int'(coeff_num), 0);
        wait_cc(dr_falls);
        wait_idle();

        // samples during reload: second one overruns, one burst afterwards
        push_reload();
        exp_q[3].push_back(1);
        exp_q[1].push_back(2);
        new_coeff_set = 1'b1;
        wait_lc_falls(lc_falls + 1);
        sample_valid = 1'b1;
        @(negedge clk); #1 sample_valid = 1'b0;
        @(negedge clk); #1 sample_valid = 1'b1;
        @(negedge clk); #1 sample_valid = 1'b0;
        wait_cc(dr_falls);
        wait_idle();

        // priority: reload and sample together
        push_reload();
        exp_q[1].push_back(2);
        new_coeff_set = 1'b1;
        sample_valid  = 1'b1;
        @(negedge clk); #1 sample_valid = 1'b0;
        check("prio_lc_first", int'({load_coeff, data_ready}), 2);
        wait_cc(dr_falls);
        @(negedge clk); check("prio_dr_idle_gap", int'(data_ready), 0);
        @(negedge clk); check("prio_dr_at_cdone_plus2", int'(data_ready), 1);
        wait_idle();

        // watchdog: controller never answers
        mw_en = 1'b0;
        exp_q[1].push_back(8);
        exp_q[5].push_back(1);
        sample_valid = 1'b1;
        @(negedge clk); #1 sample_valid = 1'b0;
        wait_idle();
        mw_en = 1'b1;

        // sample run ending with err
        exp_q[1].push_back(2);
        exp_q[4].push_back(1);
        err = 1'b1;
        sample_valid = 1'b1;
        @(negedge clk); #1 sample_valid = 1'b0;
        wait_idle();
        err = 1'b0;

        // reset in C_WAIT with coeff_num=2
        for (int c = 0; c < 3; c++) exp_q[0].push_back(c * 16 + 2);
        new_coeff_set = 1'b1;
        wait_lc_falls(lc_falls + 3);
        check("pre_reset_coeff", int'(coeff_num), 2);
        check("pre_reset_busy", int'(busy), 1);
        #2 n_rst = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({load_coeff, data_ready, clear_coeff_set, busy,
                    sample_overrun, sample_err, fault, coeff_num}), 0);
        new_coeff_set = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_busy", int'(busy), 0);

        repeat (5) @(negedge clk);
        for (int k = 0; k < 6; k++) check({"leftover_", names[k]}, exp_q[k].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_scheduler.md
# fir_scheduler

Sequencing front-end for the FIR filter controller. It accepts coefficient-load requests and sample arrivals from the host-side interface, and serialises them into the controller's `lc`/`dr` handshake, using `modwait` to track completion. A four-coefficient reload runs atomically, and one sample can be held pending behind it. It also provides a watchdog and error/overrun reporting.

## Interface
- `TIMEOUT`, default 32: max cycles an issued `lc`/`dr` may wait for `modwait` to rise before faulting; legal range 2..255.
- `clk` input 1: system clock, rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `new_coeff_set` input 1: level; host requests a reload of all 4 coefficients.
- `sample_valid` input 1: one-cycle pulse; a new sample is in the sample register.
- `modwait` input 1: controller busy flag (registered in controller).
- `err` input 1: controller error flag.
- `load_coeff` output 1: drives controller `lc`.
- `data_ready` output 1: drives controller `dr`.
- `coeff_num` output 2: index of the coefficient currently being loaded; selects the host coefficient register.
- `clear_coeff_set` output 1: one-cycle pulse when the reload completes; host clears `new_coeff_set`.
- `busy` output 1: high in any state other than IDLE.
- `sample_overrun` output 1: one-cycle pulse; a sample was dropped.
- `sample_err` output 1: one-cycle pulse; the sample run ended with `err`=1.
- `fault` output 1: one-cycle pulse; watchdog expiry.

## Operation
- States: IDLE, C_ISSUE, C_WAIT, C_DONE, S_ISSUE, S_WAIT, FAULT.
- All outputs are Moore/registered:
  - `load_coeff` = C_ISSUE.
  - `data_ready` = S_ISSUE.
  - `clear_coeff_set` = C_DONE.
  - `fault` = FAULT.
- IDLE:
  - If `new_coeff_set`=1, go to C_ISSUE with `coeff_num`=0. This takes priority over samples.
  - Else if `pend` or `sample_valid`, go to S_ISSUE and clear `pend`.
- C_ISSUE:
  - Hold `load_coeff` until `modwait`=1 is sampled, then go to C_WAIT.
  - `load_coeff` is still high in the cycle where `modwait`=1 is sampled.
- C_WAIT: when `modwait`=0:
  - If `coeff_num`=3, go to C_DONE.
  - Else increment `coeff_num` and go to C_ISSUE.
- C_DONE: one cycle, then IDLE; `coeff_num` returns to 0.
- S_ISSUE:
  - Hold `data_ready` until `modwait`=1 is sampled, then go to S_WAIT.
  - Holding it through that cycle guarantees the controller sees `dr` in both its IDLE and LOAD_SAMPLE states.
- S_WAIT: when `modwait`=0, go to IDLE; pulse `sample_err` if `err`=1 in that cycle.
- Pending sample:
  - A 1-deep flag `pend` is set by `sample_valid` arriving in any non-IDLE state.
  - If `sample_valid` arrives while `pend`=1, pulse `sample_overrun`; `pend` stays 1.
- Watchdog:
  - An 8-bit counter is cleared on entry to C_ISSUE/S_ISSUE and increments each cycle spent there.
  - If `modwait` is still 0 when the count reaches `TIMEOUT`-1, go to FAULT.
- FAULT: one cycle, then IDLE.
  - `coeff_num` is cleared and `pend` is cleared.
  - An unserved `new_coeff_set` remains asserted, so the reload restarts from coefficient 0.
- C_WAIT/S_WAIT have no timeout; the controller always releases `modwait`.

## Timing
- Reset state:
  - State is IDLE.
  - All outputs are 0, `coeff_num`=0, `pend`=0, counter=0.
- Sample latency: `sample_valid` at edge t (IDLE) gives `data_ready`=1 from t+1.
- With the controller model (`modwait` rises one cycle after `dr`), `data_ready` is high for exactly 2 cycles.
- Reload latency: `new_coeff_set` seen at t gives `load_coeff`=1 from t+1.
- `clear_coeff_set` follows one cycle after the fourth `modwait` fall.
- The host must deassert `new_coeff_set` by the edge ending C_DONE. IDLE does not re-trigger if it does.
- Simultaneous `new_coeff_set` and `sample_valid` in IDLE:
  - The reload starts; the sample is captured into `pend`.
  - The sample is served after C_DONE→IDLE, with `data_ready` at C_DONE+2.
- `sample_valid` in the same cycle a run ends (S_WAIT→IDLE): it is captured into `pend` (not dropped) and served on the next IDLE cycle.
- Reset mid-operation returns to the reset state immediately. A partial reload is abandoned and `pend` is lost.

## Test plan
- Reset check: assert `n_rst`=0 mid-C_WAIT with `coeff_num`=2 → all outputs 0 and `coeff_num`=0 asynchronously. After release with no requests, `busy`=0.
- Reload: `new_coeff_set`=1 with the controller model → `load_coeff` pulses 4 times with `coeff_num` 0,1,2,3. Each pulse is 2 cycles wide. Then one `clear_coeff_set` pulse, then IDLE.
- Single sample: `sample_valid` at t → `data_ready` high at t+1 and t+2. `busy` stays high until `modwait` falls, then returns to 0. `sample_err`=0.
- Sample during reload: one `sample_valid` during C_WAIT, then a second one → `sample_overrun` pulses once. Exactly one `data_ready` burst follows `clear_coeff_set`.
- Priority: `new_coeff_set` and `sample_valid` in the same IDLE cycle → `load_coeff` first. `data_ready` asserts only after C_DONE.
- Error and watchdog:
  - `TIMEOUT`=8 with `modwait` held 0 → `data_ready` high for 8 cycles, then `fault` pulses and the block returns to IDLE.
  - A sample run whose `modwait` falls with `err`=1 → one `sample_err` pulse.
